// File: rtl/pi1_sram.sv
// PI1 slave bridging 32-bit word ops onto a 16-bit asynchronous SRAM.
// Define PI1_SRAM_HALFSKIP_EN to bypass write halves whose byte enables are all clear.
module pi1_sram #(
  parameter int ARCHBITSZ     = 32,
  parameter int SRAMADDRBITSZ = 18,
  parameter int WAITCYCLES    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               pi1_op_i,
  input  logic [ARCHBITSZ-3:0]     pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]     pi1_data_i,
  output logic [ARCHBITSZ-1:0]     pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]   pi1_sel_i,
  output logic                     pi1_rdy_o,
  output logic [SRAMADDRBITSZ-1:0] sram_addr_o,
  input  logic [15:0]              sram_dq_i,
  output logic [15:0]              sram_dq_o,
  output logic                     sram_dq_oe_o,
  output logic                     sram_ce_n_o,
  output logic                     sram_oe_n_o,
  output logic                     sram_we_n_o,
  output logic [1:0]               sram_be_n_o
);

  typedef enum logic [2:0] {
    IDLE,
    RDLO,
    RDHI,
    WRLO,
    WRHI
  } state_e;

  localparam logic [3:0] LAST = 4'(WAITCYCLES);
  localparam int AW = SRAMADDRBITSZ - 1;

  state_e state_q, state_d, first_wr;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0] sel_q, sel_d;
  logic [31:0] rdat_q, rdat_d;
  logic rdy_q, rdy_d;
  logic [SRAMADDRBITSZ-1:0] saddr_q, saddr_d;
  logic [15:0] dq_q, dq_d;
  logic dq_oe_q, dq_oe_d;
  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic [1:0] be_n_q, be_n_d;

  logic accept, last, skip_lo, skip_hi;
  logic rd, wr, hi;
  logic unused_addr;

  assign unused_addr = ^pi1_addr_i[ARCHBITSZ-3:AW];

  always_comb begin
    accept = (state_q == IDLE) && (pi1_op_i != 2'b00);
    op_d   = op_q;
    addr_d = addr_q;
    wdat_d = wdat_q;
    sel_d  = sel_q;
    if (accept) begin
      op_d   = pi1_op_i;
      addr_d = pi1_addr_i[AW-1:0];
      wdat_d = pi1_data_i;
      sel_d  = pi1_sel_i;
    end

    skip_lo = 1'b0;
    skip_hi = 1'b0;
`ifdef PI1_SRAM_HALFSKIP_EN
    skip_lo = (sel_d[1:0] == 2'b00);
    skip_hi = (sel_d[3:2] == 2'b00);
`endif
    first_wr = skip_lo ? (skip_hi ? IDLE : WRHI) : WRLO;

    last    = (cnt_q == LAST);
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = op_d[1] ? RDLO : first_wr;
      RDLO: if (last) state_d = RDHI;
      RDHI: if (last) state_d = (op_q == 2'b11) ? first_wr : IDLE;
      WRLO: if (last) state_d = skip_hi ? IDLE : WRHI;
      WRHI: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_d != state_q) cnt_d = 4'd0;
    else cnt_d = cnt_q + 4'd1;

    // Capture each half on the final cycle of its read phase
    rdat_d = rdat_q;
    if (last && state_q == RDLO) rdat_d[15:0] = sram_dq_i;
    if (last && state_q == RDHI) rdat_d[31:16] = sram_dq_i;

    rd = (state_d == RDLO) || (state_d == RDHI);
    wr = (state_d == WRLO) || (state_d == WRHI);
    hi = (state_d == RDHI) || (state_d == WRHI);

    rdy_d   = (state_d == IDLE);
    ce_n_d  = ~(rd | wr);
    oe_n_d  = ~rd;
    dq_oe_d = wr;
    we_n_d  = ~(wr && cnt_d != LAST);

    be_n_d = 2'b11;
    if (rd) be_n_d = 2'b00;
    if (wr) be_n_d = hi ? ~sel_d[3:2] : ~sel_d[1:0];

    dq_d = dq_q;
    if (wr) dq_d = hi ? wdat_d[31:16] : wdat_d[15:0];

    saddr_d = saddr_q;
    if (rd || wr) saddr_d = {addr_d, hi};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'b00;
      addr_q  <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      rdy_q   <= 1'b1;
      saddr_q <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      rdy_q   <= rdy_d;
      saddr_q <= saddr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  assign pi1_data_o   = rdat_q;
  assign pi1_rdy_o    = rdy_q;
  assign sram_addr_o  = saddr_q;
  assign sram_dq_o    = dq_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_be_n_o  = be_n_q;

endmodule

// File: tb/tb_pi1_sram.sv
// Directed bench for pi1_sram with a byte-laned 16-bit SRAM model.
// Expectations follow PI1_SRAM_HALFSKIP_EN when it is defined for the build.
module tb_pi1_sram;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  pi1_op_i = 2'b00;
  logic [29:0] pi1_addr_i = '0;
  logic [31:0] pi1_data_i = '0;
  logic [31:0] pi1_data_o;
  logic [3:0]  pi1_sel_i = '0;
  logic        pi1_rdy_o;
  logic [17:0] sram_addr_o;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe_o, ce_n, oe_n, we_n;
  logic [1:0]  be_n;

  logic [15:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [15:0] pl_d = '0;
  logic        unused_tb;

  int errs = 0;
  int checks = 0;
  int nlow, nwe;
  logic tmo;

  pi1_sram dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pi1_op_i(pi1_op_i),
    .pi1_addr_i(pi1_addr_i),
    .pi1_data_i(pi1_data_i),
    .pi1_data_o(pi1_data_o),
    .pi1_sel_i(pi1_sel_i),
    .pi1_rdy_o(pi1_rdy_o),
    .sram_addr_o(sram_addr_o),
    .sram_dq_i(sram_dq_i),
    .sram_dq_o(sram_dq_o),
    .sram_dq_oe_o(sram_dq_oe_o),
    .sram_ce_n_o(ce_n),
    .sram_oe_n_o(oe_n),
    .sram_we_n_o(we_n),
    .sram_be_n_o(be_n)
  );

  always #5 clk_i = ~clk_i;

  assign unused_tb = ^sram_addr_o[17:8];
  assign sram_dq_i = (!ce_n && !oe_n) ? mem[sram_addr_o[7:0]] : 16'h0;

  always @(posedge clk_i) begin
    if (pl_en) mem[pl_a] = pl_d;
    else if (!ce_n && !we_n && sram_dq_oe_o) begin
      if (!be_n[0]) mem[sram_addr_o[7:0]][7:0] = sram_dq_o[7:0];
      if (!be_n[1]) mem[sram_addr_o[7:0]][15:8] = sram_dq_o[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    pl_a = a;
    pl_d = d;
    pl_en = 1'b1;
    @(posedge clk_i);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input bit inj);
    pi1_op_i = op;
    pi1_addr_i = a;
    pi1_data_i = d;
    pi1_sel_i = s;
    @(posedge clk_i);
    #1 pi1_op_i = 2'b00;
    nlow = 0;
    nwe = 0;
    tmo = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (pi1_rdy_o) begin
        tmo = 1'b0;
        break;
      end
      nlow++;
      if (!we_n) nwe++;
      if (inj && nlow == 1) begin
        pi1_op_i = 2'b01;
        pi1_addr_i = 30'h8;
        pi1_data_i = 32'hFFFF_FFFF;
        pi1_sel_i = 4'hF;
      end
      if (inj && nlow == 2) pi1_op_i = 2'b00;
    end
    chk("timeout", {31'b0, tmo}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_rdy", {31'b0, pi1_rdy_o}, 32'd1);
    chk("rst_data", pi1_data_o, 32'h0);
    chk("rst_strb", {28'b0, ce_n, oe_n, we_n, sram_dq_oe_o}, 32'hE);
    chk("rst_be", {30'b0, be_n}, 32'h3);
    chk("rst_addr", {14'b0, sram_addr_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    poke(8'h0A, 16'h1234);
    poke(8'h0B, 16'hABCD);
    poke(8'h0C, 16'h5555);
    poke(8'h0D, 16'h6666);
    poke(8'h0E, 16'h1111);
    poke(8'h0F, 16'h2222);
    for (int i = 16; i < 20; i++) poke(8'(i), 16'h0);
    @(negedge clk_i);

    do_op(2'b10, 30'h5, 32'h0, 4'hF, 1'b0);
    chk("rd_lat", 32'(nlow), 32'd6);
    chk("rd_data", pi1_data_o, 32'hABCD1234);

    do_op(2'b01, 30'h5, 32'hDEADBEEF, 4'hF, 1'b0);
    chk("wr_lat", 32'(nlow), 32'd6);
    chk("wr_we", 32'(nwe), 32'd4);
    chk("wr_lo", {16'b0, mem[8'h0A]}, 32'hBEEF);
    chk("wr_hi", {16'b0, mem[8'h0B]}, 32'hDEAD);
    chk("wr_hold", pi1_data_o, 32'hABCD1234);

    do_op(2'b11, 30'h5, 32'h0, 4'hF, 1'b0);
    chk("rw_lat", 32'(nlow), 32'd12);
    chk("rw_we", 32'(nwe), 32'd4);
    chk("rw_old", pi1_data_o, 32'hDEADBEEF);
    chk("rw_lo", {16'b0, mem[8'h0A]}, 32'h0);
    chk("rw_hi", {16'b0, mem[8'h0B]}, 32'h0);

    do_op(2'b01, 30'h6, 32'h11112222, 4'h3, 1'b0);
`ifdef PI1_SRAM_HALFSKIP_EN
    chk("s3_lat", 32'(nlow), 32'd3);
`else
    chk("s3_lat", 32'(nlow), 32'd6);
`endif
    chk("s3_lo", {16'b0, mem[8'h0C]}, 32'h2222);
    chk("s3_hi", {16'b0, mem[8'h0D]}, 32'h6666);

    do_op(2'b01, 30'h7, 32'hAABBCCDD, 4'h6, 1'b0);
    chk("s6_lat", 32'(nlow), 32'd6);
    chk("s6_lo", {16'b0, mem[8'h0E]}, 32'hCC11);
    chk("s6_hi", {16'b0, mem[8'h0F]}, 32'h22BB);

    do_op(2'b10, 30'h20007, 32'h0, 4'hF, 1'b0);
    chk("rd_upper", pi1_data_o, 32'h22BBCC11);

    do_op(2'b01, 30'h8, 32'hFFFFFFFF, 4'h0, 1'b0);
`ifdef PI1_SRAM_HALFSKIP_EN
    chk("s0_lat", 32'(nlow), 32'd0);
`else
    chk("s0_lat", 32'(nlow), 32'd6);
`endif
    chk("s0_mem", {mem[8'h11], mem[8'h10]}, 32'h0);

    pi1_op_i = 2'b10;
    pi1_addr_i = 30'h5;
    @(posedge clk_i);
    #1 pi1_op_i = 2'b00;
    repeat (4) @(negedge clk_i);
    chk("mid_busy", {31'b0, pi1_rdy_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("arst_rdy", {31'b0, pi1_rdy_o}, 32'd1);
    chk("arst_strb", {28'b0, ce_n, oe_n, we_n, sram_dq_oe_o}, 32'hE);
    chk("arst_data", pi1_data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    do_op(2'b10, 30'h7, 32'h0, 4'hF, 1'b0);
    chk("post_lat", 32'(nlow), 32'd6);
    chk("post_data", pi1_data_o, 32'h22BBCC11);

    do_op(2'b10, 30'h6, 32'h0, 4'hF, 1'b1);
    chk("b2b_rd", pi1_data_o, 32'h66662222);
    do_op(2'b01, 30'h9, 32'h13572468, 4'hF, 1'b0);
    chk("b2b_wr_lat", 32'(nlow), 32'd6);
    do_op(2'b10, 30'h9, 32'h0, 4'hF, 1'b0);
    chk("b2b_rd2", pi1_data_o, 32'h13572468);
    chk("ignored", {mem[8'h11], mem[8'h10]}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
